pp_arb_ctrl: RTL and testbench

Single-clock controller that shares a 2-entry dual-port RAM (async read, sync write, 1-bit addresses) between two producers and drains it to one consumer as a ping-pong FIFO. Round-robin arbitration between requesters; tracks the source of each entry so the consumer sees which producer wrote it. The RAM instance sits outside this block; the controller drives its write/read address, write enable and write data, and takes its read data back.

---
 rtl/pp_arb_ctrl.sv | 115 +++++++++++
 tb/tb_pp_arb_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pp_arb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pp_arb_ctrl
//  Description : Two-producer, one-consumer ping-pong FIFO controller sharing
//                an external 2-entry dual-port RAM (async read, sync write).
//                Round-robin arbitration between producers; each entry is
//                tagged with the index of the producer that wrote it.
//  Revision    : 1.0  initial release
// ============================================================================
module pp_arb_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    // producer 0
    input  logic              i_req0_valid,
    input  logic [DATA_W-1:0] i_req0_data,
    output logic              o_req0_ready,
    // producer 1
    input  logic              i_req1_valid,
    input  logic [DATA_W-1:0] i_req1_data,
    output logic              o_req1_ready,
    // consumer
    output logic              o_out_valid,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_out_src,
    input  logic              i_out_ready,
    output logic [1:0]        o_count,
    // external RAM
    output logic              o_ram_we,
    output logic              o_ram_waddr,
    output logic              o_ram_raddr,
    output logic [DATA_W-1:0] o_ram_d,
    input  logic [DATA_W-1:0] i_ram_q
);

    localparam logic [1:0] C_CNT_FULL = 2'd2;

    logic       r_wptr;
    logic       r_rptr;
    logic [1:0] r_cnt;
    logic [1:0] r_tag;
    logic       r_last;

    logic       w_space;
    logic       w_gnt_vld;
    logic       w_gnt;
    logic       w_push;
    logic       w_pop;

    // Round-robin grant: a lone requester wins; on contention the producer
    // that was not served last wins.
    always_comb begin
        w_gnt_vld = i_req0_valid | i_req1_valid;
        w_gnt     = i_req1_valid;
        if (i_req0_valid && i_req1_valid) begin
            w_gnt = ~r_last;
        end
    end

    // Handshake qualifiers; space ignores a same-cycle pop (no pass-through).
    always_comb begin
        w_space      = (r_cnt != C_CNT_FULL);
        w_push       = w_gnt_vld & w_space & ~i_clr;
        w_pop        = (r_cnt != 2'd0) & i_out_ready & ~i_clr;
        o_req0_ready = w_space & w_gnt_vld & ~w_gnt & ~i_clr;
        o_req1_ready = w_space & w_gnt_vld &  w_gnt & ~i_clr;
    end

    // RAM and consumer-side drive; the write strobe is held off while reset
    // is asserted so nothing is written before the controller is live.
    always_comb begin
        o_ram_we    = w_push & rst_n;
        o_ram_waddr = r_wptr;
        o_ram_d     = (w_push && w_gnt) ? i_req1_data : i_req0_data;
        o_ram_raddr = r_rptr;
        o_out_valid = (r_cnt != 2'd0);
        o_out_data  = i_ram_q;
        o_out_src   = r_tag[r_rptr];
        o_count     = r_cnt;
    end

    // Pointer, occupancy, source-tag and arbiter-history state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
            r_cnt  <= 2'd0;
            r_tag  <= 2'b00;
            r_last <= 1'b1;
        end else if (i_clr) begin
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
            r_cnt  <= 2'd0;
            r_last <= 1'b1;
        end else begin
            if (w_push) begin
                r_tag[r_wptr] <= w_gnt;
                r_wptr        <= ~r_wptr;
                r_last        <= w_gnt;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pp_arb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pp_arb_ctrl
//  Description : Self-checking bench for pp_arb_ctrl with a behavioural
//                queue-based reference model and an external RAM model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pp_arb_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       r0v, r1v, ordy;
    logic [7:0] r0d, r1d;
    logic       r0rdy, r1rdy;
    logic       ovalid, osrc;
    logic [7:0] odata;
    logic [1:0] cnt;
    logic       ram_we, ram_waddr, ram_raddr;
    logic [7:0] ram_d, ram_q;

    pp_arb_ctrl #(.DATA_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clr        (clr),
        .i_req0_valid (r0v),
        .i_req0_data  (r0d),
        .o_req0_ready (r0rdy),
        .i_req1_valid (r1v),
        .i_req1_data  (r1d),
        .o_req1_ready (r1rdy),
        .o_out_valid  (ovalid),
        .o_out_data   (odata),
        .o_out_src    (osrc),
        .i_out_ready  (ordy),
        .o_count      (cnt),
        .o_ram_we     (ram_we),
        .o_ram_waddr  (ram_waddr),
        .o_ram_raddr  (ram_raddr),
        .o_ram_d      (ram_d),
        .i_ram_q      (ram_q)
    );

    always #5 clk = ~clk;

    // External 2-entry RAM: synchronous write, asynchronous read.
    logic [7:0] mem [2];
    always @(posedge clk) if (ram_we) mem[ram_waddr] <= ram_d;
    assign ram_q = mem[ram_raddr];

    // Reference model: FIFO of (source, data) plus arbiter history.
    typedef struct {
        bit       src;
        bit [7:0] d;
    } ent_t;
    ent_t q[$];
    bit   m_last;
    bit   m_wp, m_rp;
    int   n_vec = 0;
    int   n_err = 0;
    bit   acc0, acc1;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        m_last = 1'b1;
        m_wp   = 1'b0;
        m_rp   = 1'b0;
    endfunction

    // One clock cycle: drive, check combinational outputs, advance model.
    task automatic cyc(input bit v0, input bit [7:0] d0, input bit v1, input bit [7:0] d1,
                       input bit ord, input bit c);
        bit   space, gv, g, push, pop;
        ent_t e;
        r0v = v0; r0d = d0; r1v = v1; r1d = d1; ordy = ord; clr = c;
        #1;
        space = (q.size() < 2);
        gv    = v0 | v1;
        g     = (v0 && v1) ? !m_last : v1;
        push  = gv && space && !c;
        pop   = (q.size() > 0) && ord && !c;
        chk("req0_ready", {7'd0, r0rdy}, {7'd0, space && gv && !g && !c});
        chk("req1_ready", {7'd0, r1rdy}, {7'd0, space && gv &&  g && !c});
        chk("out_valid",  {7'd0, ovalid}, {7'd0, q.size() > 0});
        chk("count",      {6'd0, cnt}, 8'(q.size()));
        chk("ram_we",     {7'd0, ram_we}, {7'd0, push && rst_n});
        chk("ram_waddr",  {7'd0, ram_waddr}, {7'd0, m_wp});
        chk("ram_raddr",  {7'd0, ram_raddr}, {7'd0, m_rp});
        if (push && rst_n) chk("ram_d", ram_d, g ? d1 : d0);
        if (q.size() > 0) begin
            chk("out_data", odata, q[0].d);
            chk("out_src",  {7'd0, osrc}, {7'd0, q[0].src});
        end
        acc0 = push && !g && rst_n;
        acc1 = push &&  g && rst_n;
        @(posedge clk);
        if (rst_n) begin
            if (c) begin
                q.delete();
                m_last = 1'b1;
                m_wp   = 1'b0;
                m_rp   = 1'b0;
            end else begin
                if (pop) begin
                    void'(q.pop_front());
                    m_rp = !m_rp;
                end
                if (push) begin
                    e.src = g;
                    e.d   = g ? d1 : d0;
                    q.push_back(e);
                    m_wp   = !m_wp;
                    m_last = g;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int n0, n1;
        rst_n = 1'b0; clr = 1'b0; r0v = 1'b0; r1v = 1'b0; ordy = 1'b0;
        r0d = 8'h00; r1d = 8'h00;
        model_reset();
        @(negedge clk);

        // Reset hold with random inputs: state frozen, no writes.
        for (int i = 0; i < 4; i++) begin
            cyc(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom),
                1'($urandom), 1'($urandom));
        end
        #1;
        chk("reset out_src", {7'd0, osrc}, 8'h00);
        rst_n = 1'b1;

        // First write after reset, then observe it one cycle later.
        cyc(1, 8'hA5, 0, 8'h00, 0, 0);
        chk("first out_data", odata, 8'hA5);
        cyc(0, 8'h00, 0, 8'h00, 1, 0);

        // Round-robin with both producers continuously valid.
        cyc(0, 8'h00, 0, 8'h00, 0, 1);
        n0 = 0; n1 = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1, 8'(8'h10 + n0), 1, 8'(8'h20 + n1), 1, 0);
            n0 += int'(acc0);
            n1 += int'(acc1);
        end
        chk("rr grants0", 8'(n0), 8'd4);
        chk("rr grants1", 8'(n1), 8'd4);
        for (int i = 0; i < 3; i++) cyc(0, 8'h00, 0, 8'h00, 1, 0);

        // Full / back-pressure.
        cyc(0, 8'h00, 0, 8'h00, 0, 1);
        cyc(0, 8'h00, 1, 8'h01, 0, 0);
        cyc(0, 8'h00, 1, 8'h02, 0, 0);
        cyc(1, 8'h55, 1, 8'h03, 0, 0);
        cyc(0, 8'h00, 1, 8'h03, 1, 0);
        cyc(0, 8'h00, 1, 8'h03, 0, 0);
        chk("bp accepted", {7'd0, acc1}, 8'h01);
        for (int i = 0; i < 3; i++) cyc(0, 8'h00, 0, 8'h00, 1, 0);

        // Simultaneous push/pop at occupancy 1 across pointer wrap.
        cyc(1, 8'h40, 0, 8'h00, 0, 0);
        for (int i = 0; i < 8; i++) cyc(1, 8'(8'h41 + i), 0, 8'h00, 1, 0);

        // Flush while full with both producers valid.
        cyc(1, 8'h77, 0, 8'h00, 0, 0);
        cyc(1, 8'h66, 1, 8'h99, 0, 1);
        cyc(1, 8'h61, 1, 8'h91, 0, 0);
        chk("post-clr grant0", {7'd0, acc0}, 8'h01);
        for (int i = 0; i < 2; i++) cyc(0, 8'h00, 0, 8'h00, 1, 0);

        // Single producer, then contention.
        for (int i = 0; i < 4; i++) cyc(0, 8'h00, 1, 8'(8'hB0 + i), 1, 0);
        cyc(1, 8'hC0, 1, 8'hB4, 1, 0);
        chk("single then rr", {7'd0, acc0}, 8'h01);
        for (int i = 0; i < 2; i++) cyc(0, 8'h00, 0, 8'h00, 1, 0);

        // Randomized traffic with rare flushes and one mid-run reset pulse.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                chk("async reset count", {6'd0, cnt}, 8'h00);
                chk("async reset valid", {7'd0, ovalid}, 8'h00);
                #1;
                rst_n = 1'b1;
            end
            cyc(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
